// File: rtl/i2c_ram_arbiter_if.sv
// Bus bundle between the two requesters (A: I2C slave, B: local host), the arbiter and the RAM.
// master = requester/RAM side, slave = arbiter side.
interface i2c_ram_arbiter_if;
    logic       a_req;
    logic       a_we;
    logic [7:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_gnt;
    logic [7:0] a_rdata;
    logic       a_rvalid;
    logic       a_err;

    logic       b_req;
    logic       b_we;
    logic [7:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_gnt;
    logic [7:0] b_rdata;
    logic       b_rvalid;

    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rdata, a_rvalid, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rdata, a_rvalid, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/i2c_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM, with an optional
// write-protected upper address window for port A.
module i2c_ram_arbiter #(
    parameter logic [7:0] PROT_BASE = 8'hF0,
    parameter int         PROT_EN   = 1
) (
    input  logic               clk,
    input  logic               reset,
    i2c_ram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       sel_b_q, sel_b_d;     // port being serviced: 0 = A, 1 = B
    logic       last_b_q, last_b_d;   // port granted most recently
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;
    logic       pick_b;
    logic       prot_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            sel_b_q   <= sel_b_d;
            last_b_q  <= last_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_b_d   = sel_b_q;
        last_b_d  = last_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = addr_q;
        bus.ram_wdata = wdata_q;
        bus.a_gnt     = 1'b0;
        bus.a_rvalid  = 1'b0;
        bus.a_err     = 1'b0;
        bus.a_rdata   = a_rdata_q;
        bus.b_gnt     = 1'b0;
        bus.b_rvalid  = 1'b0;
        bus.b_rdata   = b_rdata_q;

        // B wins only if A is absent or A was the last one served
        pick_b   = bus.b_req & (~bus.a_req | ~last_b_q);
        prot_hit = (PROT_EN != 0) && !sel_b_q && we_q && (addr_q >= PROT_BASE);

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    sel_b_d = pick_b;
                    we_d    = pick_b ? bus.b_we    : bus.a_we;
                    addr_d  = pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // a dropped protected write still counts as a grant for fairness
                last_b_d      = sel_b_q;
                bus.ram_en    = ~prot_hit;
                bus.ram_we    = we_q & ~prot_hit;
                bus.a_gnt     = ~sel_b_q;
                bus.b_gnt     = sel_b_q;
                bus.a_err     = prot_hit;
                state_d       = we_q ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                // data is forwarded in the rvalid cycle and registered for later
                if (sel_b_q) begin
                    b_rdata_d    = bus.ram_rdata;
                    bus.b_rdata  = bus.ram_rdata;
                    bus.b_rvalid = 1'b1;
                end else begin
                    a_rdata_d    = bus.ram_rdata;
                    bus.a_rdata  = bus.ram_rdata;
                    bus.a_rvalid = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // an access interrupted by reset must not be seen at all
        if (reset) begin
            bus.ram_en   = 1'b0;
            bus.ram_we   = 1'b0;
            bus.a_gnt    = 1'b0;
            bus.a_rvalid = 1'b0;
            bus.a_err    = 1'b0;
            bus.b_gnt    = 1'b0;
            bus.b_rvalid = 1'b0;
            bus.a_rdata  = a_rdata_q;
            bus.b_rdata  = b_rdata_q;
        end
    end
endmodule
